// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings and FSM state type for the sequential ALU.
package alu_seq_pkg;

   localparam logic [3:0] OP_AND   = 4'h0;
   localparam logic [3:0] OP_OR    = 4'h1;
   localparam logic [3:0] OP_XOR   = 4'h2;
   localparam logic [3:0] OP_NOT   = 4'h3;
   localparam logic [3:0] OP_ADD   = 4'h4;
   localparam logic [3:0] OP_SUB   = 4'h5;
   localparam logic [3:0] OP_INC   = 4'h6;
   localparam logic [3:0] OP_DEC   = 4'h7;
   localparam logic [3:0] OP_SHL   = 4'h8;
   localparam logic [3:0] OP_SHR   = 4'h9;
   localparam logic [3:0] OP_ASR   = 4'hA;
   localparam logic [3:0] OP_ROL   = 4'hB;
   localparam logic [3:0] OP_PASSA = 4'hC;
   localparam logic [3:0] OP_PASSB = 4'hD;
   localparam logic [3:0] OP_SLTU  = 4'hE;
   localparam logic [3:0] OP_MUL   = 4'hF;

   typedef enum logic {
      IDLE    = 1'b0,
      MUL_RUN = 1'b1
   } state_t;

endpackage

// File: rtl/alu_seq_comb.sv
// Combinational single-cycle ALU datapath: s, cout and signed overflow.
// MUL is handled by the sequencer; here it yields all zeros.
module alu_seq_comb
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic [3:0]       sel,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);

   logic [WIDTH-1:0] opb;
   logic             ci;
   logic             arith;
   logic [WIDTH:0]   sum;

   // ADD/SUB/INC/DEC share one adder with a selected second operand and carry-in
   always_comb begin
      opb   = b;
      ci    = cin;
      arith = 1'b0;
      case (sel)
         OP_ADD: begin opb = b;              ci = cin;  arith = 1'b1; end
         OP_SUB: begin opb = ~b;             ci = cin;  arith = 1'b1; end
         OP_INC: begin opb = '0;             ci = 1'b1; arith = 1'b1; end
         OP_DEC: begin opb = '1;             ci = 1'b0; arith = 1'b1; end
         default: ;
      endcase
   end

   assign sum = {1'b0, a} + {1'b0, opb} + {{WIDTH{1'b0}}, ci};

   always_comb begin
      s    = '0;
      cout = 1'b0;
      ovf  = 1'b0;
      case (sel)
         OP_AND:   s = a & b;
         OP_OR:    s = a | b;
         OP_XOR:   s = a ^ b;
         OP_NOT:   s = ~a;
         OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
            s    = sum[WIDTH-1:0];
            cout = sum[WIDTH];
         end
         OP_SHL:   begin s = {a[WIDTH-2:0], cin};      cout = a[WIDTH-1]; end
         OP_SHR:   begin s = {cin, a[WIDTH-1:1]};      cout = a[0];       end
         OP_ASR:   begin s = {a[WIDTH-1], a[WIDTH-1:1]}; cout = a[0];     end
         OP_ROL:   begin s = {a[WIDTH-2:0], a[WIDTH-1]}; cout = a[WIDTH-1]; end
         OP_PASSA: s = a;
         OP_PASSB: s = b;
         OP_SLTU:  begin
            s    = (a < b) ? WIDTH'(1) : '0;
            cout = (a >= b);
         end
         default:  ;
      endcase
      ovf = arith && (a[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
   end

endmodule

// File: rtl/alu_seq_param.sv
// Registered ALU with valid/ready on both sides and an iterative shift-add multiply.
// Single-cycle ops: 1 cycle; MUL: WIDTH+1 cycles. One op in flight; stalls while a result is unconsumed.
module alu_seq_param
   import alu_seq_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic [3:0]       sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic [WIDTH-1:0] s_hi,
   output logic             cout,
   output logic             zero,
   output logic             neg,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH);

   state_t             state_q, state_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CW-1:0]      cnt_q, cnt_d;

   logic               out_valid_q, out_valid_d;
   logic [WIDTH-1:0]   s_q, s_d;
   logic [WIDTH-1:0]   s_hi_q, s_hi_d;
   logic               cout_q, cout_d;
   logic               zero_q, zero_d;
   logic               neg_q, neg_d;
   logic               ovf_q, ovf_d;

   logic [WIDTH-1:0]   alu_s;
   logic               alu_cout;
   logic               alu_ovf;
   logic [2*WIDTH-1:0] acc_sum;
   logic               accept;

   alu_seq_comb #(.WIDTH(WIDTH)) u_comb (
      .a    (a),
      .b    (b),
      .cin  (cin),
      .sel  (sel),
      .s    (alu_s),
      .cout (alu_cout),
      .ovf  (alu_ovf)
   );

   assign in_ready = (state_q == IDLE) && !(out_valid_q && !out_ready);
   assign accept   = in_valid && in_ready;
   assign acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q && !out_ready;
      s_d         = s_q;
      s_hi_d      = s_hi_q;
      cout_d      = cout_q;
      zero_d      = zero_q;
      neg_d       = neg_q;
      ovf_d       = ovf_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (MUL_EN && (sel == OP_MUL)) begin
                  state_d  = MUL_RUN;
                  acc_d    = '0;
                  mcand_d  = {{WIDTH{1'b0}}, a};
                  mplier_d = b;
                  cnt_d    = '0;
               end else begin
                  out_valid_d = 1'b1;
                  s_d         = alu_s;
                  s_hi_d      = '0;
                  cout_d      = alu_cout;
                  zero_d      = (alu_s == '0);
                  neg_d       = alu_s[WIDTH-1];
                  ovf_d       = alu_ovf;
               end
            end
         end
         MUL_RUN: begin
            // One multiplier bit per cycle; the last step's sum goes straight to the outputs
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d     = IDLE;
               out_valid_d = 1'b1;
               s_d         = acc_sum[WIDTH-1:0];
               s_hi_d      = acc_sum[2*WIDTH-1:WIDTH];
               cout_d      = |acc_sum[2*WIDTH-1:WIDTH];
               zero_d      = (acc_sum == '0);
               neg_d       = acc_sum[WIDTH-1];
               ovf_d       = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         s_q         <= '0;
         s_hi_q      <= '0;
         cout_q      <= 1'b0;
         zero_q      <= 1'b0;
         neg_q       <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         s_q         <= s_d;
         s_hi_q      <= s_hi_d;
         cout_q      <= cout_d;
         zero_q      <= zero_d;
         neg_q       <= neg_d;
         ovf_q       <= ovf_d;
      end
   end

   assign out_valid = out_valid_q;
   assign s         = s_q;
   assign s_hi      = s_hi_q;
   assign cout      = cout_q;
   assign zero      = zero_q;
   assign neg       = neg_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_alu_seq_param.sv
// Randomised and directed bench for alu_seq_param (WIDTH=8) against an arithmetic reference model.
module tb_alu_seq_param;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic [3:0]   sel = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] s;
   logic [W-1:0] s_hi;
   logic         cout;
   logic         zero;
   logic         neg;
   logic         ovf;

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      logic [W-1:0] s;
      logic [W-1:0] s_hi;
      logic         cout;
      logic         zero;
      logic         neg;
      logic         ovf;
   } res_t;

   alu_seq_param #(.WIDTH(W), .MUL_EN(1'b1)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sel       (sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .s_hi      (s_hi),
      .cout      (cout),
      .zero      (zero),
      .neg       (neg),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   // Reference built from plain integer arithmetic on the opcode definitions
   function automatic res_t model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                  input logic tc, input logic [3:0] tsel);
      res_t r;
      int ia, ib, sa, sb, ic, u, v, p;
      ia = int'(ta);
      ib = int'(tb);
      sa = (ia >= 128) ? ia - 256 : ia;
      sb = (ib >= 128) ? ib - 256 : ib;
      ic = tc ? 1 : 0;
      u = 0; v = 0; p = 0;
      r.s = '0; r.s_hi = '0; r.cout = 1'b0; r.ovf = 1'b0;
      case (tsel)
         4'h0: r.s = ta & tb;
         4'h1: r.s = ta | tb;
         4'h2: r.s = ta ^ tb;
         4'h3: r.s = W'(255 - ia);
         4'h4: begin u = ia + ib + ic;         v = sa + sb + ic;     end
         4'h5: begin u = ia + (255 - ib) + ic; v = sa - sb - 1 + ic; end
         4'h6: begin u = ia + 1;               v = sa + 1;           end
         4'h7: begin u = ia + 255;             v = sa - 1;           end
         4'h8: begin r.s = W'((ia * 2 + ic) % 256);   r.cout = (ia >= 128); end
         4'h9: begin r.s = W'(ia / 2 + ic * 128);     r.cout = (ia % 2 == 1); end
         4'hA: begin r.s = W'((sa >>> 1) & 255);      r.cout = (ia % 2 == 1); end
         4'hB: begin r.s = W'((ia * 2 + ia / 128) % 256); r.cout = (ia >= 128); end
         4'hC: r.s = ta;
         4'hD: r.s = tb;
         4'hE: begin r.s = (ia < ib) ? W'(1) : W'(0); r.cout = (ia >= ib); end
         default: begin
            p = ia * ib;
            r.s    = W'(p % 256);
            r.s_hi = W'(p / 256);
            r.cout = (p >= 256);
         end
      endcase
      if (tsel >= 4'h4 && tsel <= 4'h7) begin
         r.s    = W'(u % 256);
         r.cout = (u > 255);
         r.ovf  = (v > 127) || (v < -128);
      end
      r.zero = (tsel == 4'hF) ? (p == 0) : (r.s == '0);
      r.neg  = r.s[W-1];
      return r;
   endfunction

   // Issue one op with out_ready=1, scramble operands after capture, check result and latency
   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tc, input logic [3:0] tsel);
      res_t e;
      int n;
      int lat;
      e = model(ta, tb, tc, tsel);
      out_ready = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      check("in_ready_pre", in_ready, 1);
      a = ta; b = tb; cin = tc; sel = tsel; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sel = 4'($urandom);
      if (tsel == 4'hF) check("mul_busy", in_ready, 0);
      lat = 1;
      while (!out_valid && lat < 50) begin
         @(posedge clk); #1; lat++;
      end
      check("latency", lat, (tsel == 4'hF) ? W + 1 : 1);
      check("s", s, e.s);
      check("s_hi", s_hi, e.s_hi);
      check("cout", cout, e.cout);
      check("zero", zero, e.zero);
      check("neg", neg, e.neg);
      check("ovf", ovf, e.ovf);
   endtask

   initial begin
      #2 rst = 1'b1;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_s", s, 0);
      check("rst_s_hi", s_hi, 0);
      check("rst_flags", {cout, zero, neg, ovf}, 0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("rst_in_ready", in_ready, 1);

      do_op(8'h73, 8'hAF, 1'b0, 4'h4);
      check("add_s", s, 8'h22);
      check("add_cout", cout, 1);
      do_op(8'h80, 8'h01, 1'b1, 4'h5);
      check("sub_s", s, 8'h7F);
      check("sub_ovf", ovf, 1);
      do_op(8'h05, 8'h06, 1'b0, 4'hE);
      check("sltu_s", s, 8'h01);
      do_op(8'hFF, 8'hFF, 1'b0, 4'hF);
      check("mul_s", s, 8'h01);
      check("mul_s_hi", s_hi, 8'hFE);
      do_op(8'h81, 8'h00, 1'b0, 4'hB);
      check("rol_s", s, 8'h03);
      do_op(8'h01, 8'h00, 1'b1, 4'h9);
      check("shr_s", s, 8'h80);
      do_op(8'hF0, 8'h0F, 1'b0, 4'h0);
      check("and_zero", zero, 1);
      do_op(8'h00, 8'h37, 1'b0, 4'hF);
      do_op(8'h00, 8'h00, 1'b0, 4'h7);

      // Back-to-back single-cycle ops: one result per cycle
      @(posedge clk); #1;
      a = 8'h10; b = 8'h20; cin = 1'b0; sel = 4'h4; in_valid = 1'b1;
      @(posedge clk); #1;
      check("b2b_rdy", in_ready, 1);
      check("b2b_s0", s, 8'h30);
      a = 8'h0F; b = 8'h3C; sel = 4'h2;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("b2b_vld", out_valid, 1);
      check("b2b_s1", s, 8'h33);

      // Backpressure: ADD held while out_ready=0, OR waits until released
      @(posedge clk); #1;
      out_ready = 1'b0;
      a = 8'h01; b = 8'h01; cin = 1'b0; sel = 4'h4; in_valid = 1'b1;
      @(posedge clk); #1;
      check("bp_vld", out_valid, 1);
      check("bp_s", s, 8'h02);
      a = 8'h0C; b = 8'h30; sel = 4'h1;
      #1 check("bp_blocked", in_ready, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("bp_hold_s", s, 8'h02);
      check("bp_hold_vld", out_valid, 1);
      check("bp_hold_rdy", in_ready, 0);
      out_ready = 1'b1;
      #1 check("bp_release", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp_or_vld", out_valid, 1);
      check("bp_or_s", s, 8'h3C);
      @(posedge clk); #1;
      check("bp_drain", out_valid, 0);

      // Reset three cycles into a multiply
      do_op(8'h55, 8'h22, 1'b0, 4'h4);
      a = 8'hFF; b = 8'hFF; cin = 1'b0; sel = 4'hF; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      check("mid_busy", in_ready, 0);
      rst = 1'b1;
      #1;
      check("mid_rst_vld", out_valid, 0);
      check("mid_rst_s", s, 0);
      check("mid_rst_s_hi", s_hi, 0);
      check("mid_rst_flags", {cout, zero, neg, ovf}, 0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      #1 check("mid_rst_rdy", in_ready, 1);
      do_op(8'h12, 8'h34, 1'b1, 4'h4);
      check("post_rst_add", s, 8'h47);

      for (int i = 0; i < 150; i++)
         do_op(W'($urandom), W'($urandom), 1'($urandom), 4'($urandom_range(0, 15)));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
